// File: rtl/msrv32_branch_predictor.sv
// Direct-mapped table of 2-bit saturating counters giving a registered
// taken/not-taken prediction, with a resolved-outcome update port and mispredict counter.
module msrv32_branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int INDEX_W = 6,
  parameter int CNT_W   = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             predict_valid_in,
  input  logic [31:0]      pc_in,
  input  logic [4:0]       opcode_6_to_2_in,
  output logic             predict_valid_out,
  output logic             predict_taken_out,
  input  logic             update_valid_in,
  input  logic [31:0]      update_pc_in,
  input  logic             update_taken_in,
  input  logic             update_predicted_in,
  output logic             ready_out,
  output logic [CNT_W-1:0] mispredict_count_out
);

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [INDEX_W-1:0]   init_idx_r;
  logic [1:0]           table_r [ENTRIES];

  logic [INDEX_W-1:0]   pred_idx_s;
  logic [INDEX_W-1:0]   upd_idx_s;
  logic [1:0]           upd_cnt_s;
  logic [1:0]           upd_next_s;
  logic                 taken_s;
  logic                 pc_unused_s;

  assign pred_idx_s  = pc_in[INDEX_W+1:2];
  assign upd_idx_s   = update_pc_in[INDEX_W+1:2];
  assign pc_unused_s = ^{pc_in[31:INDEX_W+2], pc_in[1:0],
                         update_pc_in[31:INDEX_W+2], update_pc_in[1:0]};
  assign ready_out   = (state_r == RUN);

  // Next-state: walk the init index once, then stay in RUN until reset
  always_comb begin
    state_s = state_r;
    case (state_r)
      INIT: begin
        if (init_idx_r == INDEX_W'(ENTRIES - 1)) begin
          state_s = RUN;
        end else begin
          state_s = INIT;
        end
      end
      RUN:     state_s = RUN;
      default: state_s = INIT;
    endcase
  end

  // State register and init index
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r    <= INIT;
      init_idx_r <= '0;
    end else begin
      state_r <= state_s;
      if (state_r == INIT) begin
        init_idx_r <= init_idx_r + INDEX_W'(1);
      end
    end
  end

  // Prediction: jumps always taken, branches use the counter MSB
  always_comb begin
    taken_s = 1'b0;
    case (opcode_6_to_2_in)
      5'b11011, 5'b11001: taken_s = 1'b1;
      5'b11000:           taken_s = table_r[pred_idx_s][1];
      default:            taken_s = 1'b0;
    endcase
  end

  // Saturating counter step for the update port
  always_comb begin
    upd_cnt_s  = table_r[upd_idx_s];
    upd_next_s = upd_cnt_s;
    if (update_taken_in) begin
      if (upd_cnt_s != 2'b11) begin
        upd_next_s = upd_cnt_s + 2'b01;
      end else begin
        upd_next_s = upd_cnt_s;
      end
    end else begin
      if (upd_cnt_s != 2'b00) begin
        upd_next_s = upd_cnt_s - 2'b01;
      end else begin
        upd_next_s = upd_cnt_s;
      end
    end
  end

  // Counter table: no reset, INIT rewrites every entry before use
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      if (state_r == INIT) begin
        table_r[init_idx_r] <= 2'b01;
      end else if (update_valid_in) begin
        table_r[upd_idx_s] <= upd_next_s;
      end
    end
  end

  // Registered prediction outputs; reads see the pre-update counter
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      predict_valid_out <= 1'b0;
      predict_taken_out <= 1'b0;
    end else if (ready_out && predict_valid_in) begin
      predict_valid_out <= 1'b1;
      predict_taken_out <= taken_s;
    end else begin
      predict_valid_out <= 1'b0;
      predict_taken_out <= 1'b0;
    end
  end

  // Saturating mispredict counter
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mispredict_count_out <= '0;
    end else if (ready_out && update_valid_in &&
                 (update_taken_in != update_predicted_in) &&
                 (mispredict_count_out != {CNT_W{1'b1}})) begin
      mispredict_count_out <= mispredict_count_out + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_msrv32_branch_predictor.sv
// Directed self-checking bench for msrv32_branch_predictor; a second
// instance with a 4-bit mispredict counter shares all inputs to test saturation.
module tb_msrv32_branch_predictor;

  localparam logic [4:0] OP_BR   = 5'b11000;
  localparam logic [4:0] OP_JAL  = 5'b11011;
  localparam logic [4:0] OP_JALR = 5'b11001;
  localparam logic [4:0] OP_ALU  = 5'b01100;

  logic        clk = 1'b0;
  logic        rst;
  logic        pv_in;
  logic [31:0] pc;
  logic [4:0]  op;
  logic        uv_in;
  logic [31:0] upc;
  logic        utaken;
  logic        upred;

  logic        pv, pt, rdy;
  logic [15:0] mc;
  logic        pv4, pt4, rdy4;
  logic [3:0]  mc4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msrv32_branch_predictor dut (
    .clk_in(clk), .rst_in(rst),
    .predict_valid_in(pv_in), .pc_in(pc), .opcode_6_to_2_in(op),
    .predict_valid_out(pv), .predict_taken_out(pt),
    .update_valid_in(uv_in), .update_pc_in(upc),
    .update_taken_in(utaken), .update_predicted_in(upred),
    .ready_out(rdy), .mispredict_count_out(mc)
  );

  msrv32_branch_predictor #(.CNT_W(4)) dut4 (
    .clk_in(clk), .rst_in(rst),
    .predict_valid_in(pv_in), .pc_in(pc), .opcode_6_to_2_in(op),
    .predict_valid_out(pv4), .predict_taken_out(pt4),
    .update_valid_in(uv_in), .update_pc_in(upc),
    .update_taken_in(utaken), .update_predicted_in(upred),
    .ready_out(rdy4), .mispredict_count_out(mc4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    pv_in = 1'b0; uv_in = 1'b0;
  endtask

  // One update cycle, then a BRANCH prediction at the same pc checked one cycle later
  task automatic upd_then_pred(input logic [31:0] a, input logic t, input logic exp_t, input string tag);
    idle(); uv_in = 1'b1; upc = a; utaken = t; upred = t;
    tick();
    idle(); pv_in = 1'b1; pc = a; op = OP_BR;
    tick();
    check({tag, "_valid"}, {31'd0, pv}, 32'd1);
    check(tag, {31'd0, pt}, {31'd0, exp_t});
  endtask

  task automatic init_walk(input string tag);
    for (int i = 0; i < 64; i++) begin
      tick();
      check({tag, "_ready"}, {31'd0, rdy}, (i == 63) ? 32'd1 : 32'd0);
      check({tag, "_no_valid"}, {31'd0, pv}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; pv_in = 1'b1; pc = 32'h100; op = OP_BR;
    uv_in = 1'b0; upc = 32'h0; utaken = 1'b0; upred = 1'b0;
    tick(); tick();
    check("rst_ready", {31'd0, rdy}, 32'd0);
    check("rst_pv", {31'd0, pv}, 32'd0);
    check("rst_pt", {31'd0, pt}, 32'd0);
    check("rst_mc", {16'd0, mc}, 32'd0);

    rst = 1'b0;
    init_walk("init");

    // First request after INIT: weak not-taken
    tick();
    check("first_pv", {31'd0, pv}, 32'd1);
    check("first_pt", {31'd0, pt}, 32'd0);

    op = OP_JAL;  tick(); check("jal_pt", {31'd0, pt}, 32'd1);
    op = OP_JALR; tick(); check("jalr_pt", {31'd0, pt}, 32'd1);
    op = OP_ALU;  tick(); check("alu_pt", {31'd0, pt}, 32'd0);
    check("alu_pv", {31'd0, pv}, 32'd1);
    idle(); tick();
    check("idle_pv", {31'd0, pv}, 32'd0);
    check("idle_pt", {31'd0, pt}, 32'd0);

    // Saturation at pc 0x40
    upd_then_pred(32'h40, 1'b1, 1'b1, "sat_t1");
    upd_then_pred(32'h40, 1'b1, 1'b1, "sat_t2");
    upd_then_pred(32'h40, 1'b1, 1'b1, "sat_t3");
    upd_then_pred(32'h40, 1'b0, 1'b1, "sat_n1");
    upd_then_pred(32'h40, 1'b0, 1'b0, "sat_n2");
    upd_then_pred(32'h40, 1'b0, 1'b0, "sat_n3");
    upd_then_pred(32'h40, 1'b0, 1'b0, "sat_n4");
    idle(); pv_in = 1'b1; pc = 32'h40; op = OP_JAL;
    tick();
    check("jal_strong_nt", {31'd0, pt}, 32'd1);
    upd_then_pred(32'h40, 1'b1, 1'b0, "sat_floor");

    // Collision via alias: update 0x104 and predict 0x004 (both index 1)
    idle();
    uv_in = 1'b1; upc = 32'h104; utaken = 1'b1; upred = 1'b1;
    pv_in = 1'b1; pc = 32'h004; op = OP_BR;
    tick();
    check("coll_same", {31'd0, pt}, 32'd0);
    uv_in = 1'b0;
    tick();
    check("coll_next", {31'd0, pt}, 32'd1);

    // Mispredict counting: 5 mismatches, 3 matches
    idle();
    check("mc_zero", {16'd0, mc}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      uv_in = 1'b1; upc = 32'h200; utaken = 1'b1; upred = (i < 5) ? 1'b0 : 1'b1;
      tick();
    end
    idle(); tick();
    check("mc_five", {16'd0, mc}, 32'd5);
    check("mc4_five", {28'd0, mc4}, 32'd5);
    for (int i = 0; i < 20; i++) begin
      uv_in = 1'b1; upc = 32'h200; utaken = 1'b0; upred = 1'b1;
      tick();
    end
    idle(); tick();
    check("mc_25", {16'd0, mc}, 32'd25);
    check("mc4_sat", {28'd0, mc4}, 32'd15);

    // Train 0x40 to strong taken, then reset right after a request
    upd_then_pred(32'h40, 1'b1, 1'b1, "pre_rst_t1");
    upd_then_pred(32'h40, 1'b1, 1'b1, "pre_rst_t2");
    rst = 1'b1;
    tick();
    check("mid_rst_pv", {31'd0, pv}, 32'd0);
    check("mid_rst_pt", {31'd0, pt}, 32'd0);
    check("mid_rst_mc", {16'd0, mc}, 32'd0);
    check("mid_rst_mc4", {28'd0, mc4}, 32'd0);
    check("mid_rst_ready", {31'd0, rdy}, 32'd0);
    rst = 1'b0; pv_in = 1'b1; pc = 32'h40; op = OP_BR;
    init_walk("reinit");
    tick();
    check("reinit_pv", {31'd0, pv}, 32'd1);
    check("reinit_pt", {31'd0, pt}, 32'd0);
    upd_then_pred(32'h40, 1'b1, 1'b1, "reinit_weak");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
